spi_bus_arbiter: RTL

- Shares the single SPI master (one SCLK/SDIO pair) between NUM_REQ configuration requesters, e.g. the AD9517 clock-chip config engine and the ADC0/ADC1 config engines.
- Grants the bus round-robin. The grant is held for a whole burst of SPI commands while the requester keeps i_req high.
- Forwards the granted requester's commands and data to the master and returns busy and read data.
- Steers the master's chip select onto that requester's device cs_n. Replaces the ad-hoc priority mux in the device config top level.

---
 rtl/spi_bus_arbiter_pkg.sv | 37 +++
 rtl/spi_bus_arbiter_picker.sv | 39 +++
 rtl/spi_bus_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
// ============================================================================
// Module  : spi_arb_pkg
// Purpose : Shared state encoding, default sizes and width helper for the
//           SPI bus arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANTED  = 3'd1,
        CMD_WAIT = 3'd2,
        XFER     = 3'd3,
        GAP      = 3'd4
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 3;
    localparam int DEF_MOSI_W      = 24;
    localparam int DEF_MISO_W      = 8;
    localparam int DEF_START_TMO   = 256;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_WDOG_CYCLES = 65535;

    // Never returns zero so single-entry configurations still get a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = cnt_w(DEF_NUM_REQ);
    localparam int TMO_W = cnt_w(DEF_START_TMO + 1);
    localparam int GAP_W = cnt_w(DEF_GAP_CYCLES + 1);

endpackage

`default_nettype wire

// File: rtl/spi_bus_arbiter_picker.sv
// ============================================================================
// Module  : spi_rr_picker
// Purpose : Combinational round-robin encoder: first set request at or above
//           the pointer, wrapping, as one-hot grant plus index.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
// ============================================================================
// Module  : spi_bus_arbiter
// Purpose : Round-robin sharing of one SPI master between NUM_REQ config
//           engines, with chip-select steering. Optional idle-grant watchdog
//           enabled by defining SPI_ARB_WDOG_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int MOSI_DATA_WIDTH = DEF_MOSI_W,
    parameter int MISO_DATA_WIDTH = DEF_MISO_W,
    parameter int START_TMO       = DEF_START_TMO,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int WDOG_CYCLES     = DEF_WDOG_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 i_req,
    output logic [NUM_REQ-1:0]                 o_gnt,
    input  logic [NUM_REQ-1:0]                 i_wr_cmd,
    input  logic [NUM_REQ-1:0]                 i_rd_cmd,
    input  logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] i_wr_data,
    output logic [NUM_REQ-1:0]                 o_busy,
    output logic [MISO_DATA_WIDTH:0]           o_rd_data,
    output logic                               o_spi_wr_cmd,
    output logic                               o_spi_rd_cmd,
    output logic [MOSI_DATA_WIDTH-1:0]         o_spi_wr_data,
    input  logic                               i_spi_busy,
    input  logic [MISO_DATA_WIDTH:0]           i_spi_rd_data,
    input  logic                               i_spi_ncs,
    output logic [NUM_REQ-1:0]                 o_cs_n,
    output logic                               o_err
);

    localparam int IW = cnt_w(NUM_REQ);
    localparam int TW = cnt_w(START_TMO + 1);
    localparam int GW = cnt_w(GAP_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    arb_state_t state, state_nxt;

    logic [IW-1:0]              ptr;
    logic [IW-1:0]              gidx;
    logic [NUM_REQ-1:0]         pick_gnt;
    logic [IW-1:0]              pick_idx;
    logic                       pick_valid;
    logic [TW-1:0]              tmo_cnt;
    logic [GW-1:0]              gap_cnt;
    logic                       g_req;
    logic                       g_wr;
    logic                       g_rd;
    logic                       tmo_hit;
    logic                       gap_done;
    logic                       wdog_hit;
    logic                       in_session;
    logic [MOSI_DATA_WIDTH-1:0] words [NUM_REQ];
    logic [MOSI_DATA_WIDTH-1:0] g_word;

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_picker (
        .req   (i_req),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = i_wr_data[i*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
    end

    assign g_word     = words[gidx];
    assign g_req      = i_req[gidx];
    assign g_wr       = i_wr_cmd[gidx];
    assign g_rd       = i_rd_cmd[gidx];
    assign tmo_hit    = (tmo_cnt == TW'(START_TMO - 1));
    assign gap_done   = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign in_session = (state == GRANTED) || (state == CMD_WAIT) || (state == XFER);

`ifdef SPI_ARB_WDOG_EN
    localparam int WW = cnt_w(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;

    // Any command leaves GRANTED, so "stays in GRANTED" already means "idle".
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state == GRANTED && state_nxt == GRANTED) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign wdog_hit = (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pick_valid) state_nxt = GRANTED;
            GRANTED: begin
                if (g_wr || g_rd)             state_nxt = CMD_WAIT;
                else if (!g_req || wdog_hit)  state_nxt = GAP;
            end
            CMD_WAIT: begin
                if (i_spi_busy)   state_nxt = XFER;
                else if (tmo_hit) state_nxt = GRANTED;
            end
            XFER:     if (!i_spi_busy) state_nxt = GRANTED;
            GAP:      if (gap_done)    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_gnt         <= '0;
            gidx          <= '0;
            ptr           <= '0;
            o_spi_wr_cmd  <= 1'b0;
            o_spi_rd_cmd  <= 1'b0;
            o_spi_wr_data <= '0;
            o_rd_data     <= '0;
            o_err         <= 1'b0;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
        end else begin
            o_spi_wr_cmd <= 1'b0;
            o_spi_rd_cmd <= 1'b0;
            tmo_cnt      <= (state == CMD_WAIT && state_nxt == CMD_WAIT) ? tmo_cnt + 1'b1 : '0;
            gap_cnt      <= (state == GAP && state_nxt == GAP) ? gap_cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        o_gnt <= pick_gnt;
                        gidx  <= pick_idx;
                    end
                end
                GRANTED: begin
                    if (g_wr) begin
                        o_spi_wr_cmd  <= 1'b1;
                        o_spi_wr_data <= g_word;
                        if (g_rd) o_err <= 1'b1;
                    end else if (g_rd) begin
                        o_spi_rd_cmd  <= 1'b1;
                        o_spi_wr_data <= g_word;
                    end else if (!g_req || wdog_hit) begin
                        o_gnt <= '0;
                        ptr   <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
                        if (wdog_hit) o_err <= 1'b1;
                    end
                end
                CMD_WAIT: begin
                    if (!i_spi_busy && tmo_hit) o_err <= 1'b1;
                end
                XFER: begin
                    if (!i_spi_busy) o_rd_data <= i_spi_rd_data;
                end
                default: ;
            endcase
        end
    end

    // Chip select passes straight through so the master's timing is preserved.
    always_comb begin
        o_busy = '1;
        o_cs_n = '1;
        if (state == GRANTED) o_busy[gidx] = 1'b0;
        if (in_session)       o_cs_n[gidx] = i_spi_ncs;
    end

endmodule

`default_nettype wire
